// File: rtl/ui_lvds_tx.sv
// ui_lvds_tx: four-lane DDR LVDS serializer; 48-bit words leave as six bytes, MSB byte first.
// Optional PRBS7 test source is compiled in with `UI_LVDS_TX_PRBS_EN.
module ui_lvds_tx (
   input  logic        w_lvds_clk,
   input  logic        I_rstn,
   input  logic        I_enable,
   input  logic        I_train,
   input  logic [47:0] I_data,
   input  logic        I_valid,
`ifdef UI_LVDS_TX_PRBS_EN
   input  logic        I_prbs_mode,
`endif
   output logic        O_ready,
   output logic [3:0]  O_d1,
   output logic [3:0]  O_d2,
   output logic        O_word_start,
   output logic        O_underrun
);
   localparam logic [47:0] TRAIN_WORD = 48'hFFF_000_000_000;
   typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_t;
   state_t state, nxt;
   logic [2:0] cnt;
   logic [47:0] r_word, hold, src_word, sh;
   logic hold_full, boundary, hold_unload, push, prbs_sel, prbs_block, underrun;
   logic [7:0] cur;

`ifdef UI_LVDS_TX_PRBS_EN
   logic [6:0] prbs, prbs_nxt;
   logic [47:0] prbs_word;
   always_comb begin
      prbs_nxt = prbs;
      prbs_word = '0;
      for (int i = 47; i >= 0; i--) begin
         prbs_nxt = {prbs_nxt[5:0], prbs_nxt[6] ^ prbs_nxt[5]};
         prbs_word[i] = prbs_nxt[0];
      end
   end
   always_comb begin
      prbs_sel = I_prbs_mode & (nxt == DATA);
      prbs_block = I_prbs_mode & (state == DATA);
      src_word = prbs_sel ? prbs_word : TRAIN_WORD;
   end
   always_ff @(posedge w_lvds_clk or negedge I_rstn)
      if (!I_rstn) prbs <= 7'h7F;
      else if (boundary & prbs_sel) prbs <= prbs_nxt;
`else
   always_comb begin
      prbs_sel = 1'b0;
      prbs_block = 1'b0;
      src_word = TRAIN_WORD;
   end
`endif

   assign boundary = (state != IDLE) & (cnt == 3'd5);

   always_ff @(posedge w_lvds_clk or negedge I_rstn)
      if (!I_rstn) state <= IDLE;
      else state <= nxt;

   // Leaving TRAIN/DATA only happens on a word boundary so a word is never cut short.
   always_comb begin
      nxt = state;
      if (state == IDLE) nxt = I_enable ? TRAIN : IDLE;
      else if (boundary) nxt = !I_enable ? IDLE : I_train ? TRAIN : (state == DATA || hold_full) ? DATA : TRAIN;
   end

   always_comb begin
      hold_unload = boundary & (nxt == DATA) & hold_full & !prbs_sel;
      underrun = boundary & (state == DATA) & (nxt == DATA) & !hold_full & !prbs_sel;
      O_ready = (state != IDLE) & !prbs_block & (!hold_full | hold_unload);
      push = I_valid & O_ready;
      sh = r_word << {cnt, 3'b000};
      cur = sh[47:40];
   end

   always_ff @(posedge w_lvds_clk or negedge I_rstn)
      if (!I_rstn) begin
         cnt <= '0;
         r_word <= '0;
         hold <= '0;
         hold_full <= 1'b0;
         O_d1 <= '0;
         O_d2 <= '0;
         O_word_start <= 1'b0;
         O_underrun <= 1'b0;
      end else begin
         cnt <= (state == IDLE || boundary) ? 3'd0 : cnt + 3'd1;
         if (state == IDLE) r_word <= TRAIN_WORD;
         else if (boundary) r_word <= hold_unload ? hold : src_word;
         if (push) hold <= I_data;
         hold_full <= (nxt == IDLE) ? 1'b0 : push | (hold_full & !hold_unload);
         {O_d1, O_d2} <= (state == IDLE) ? 8'd0 : cur;
         O_word_start <= (state != IDLE) & (cnt == 3'd0);
         O_underrun <= underrun;
      end
endmodule

// File: tb/tb_ui_lvds_tx.sv
// tb_ui_lvds_tx: directed and random checks of ui_lvds_tx against a byte-queue reference model.
module tb_ui_lvds_tx;
   localparam logic [47:0] TRAIN_WORD = 48'hFFF_000_000_000;
   logic clk = 0, rstn = 1, enable = 0, train = 0, valid = 0;
   logic [47:0] data = '0;
   logic ready, word_start, underrun;
   logic [3:0] d1, d2;
   int total = 0, bad = 0;
   int mode = 0;
   logic [7:0] q[$];
   logic [47:0] hold[$], rx_words[$];
   logic [47:0] rx_acc = '0;
   int rx_n = 0;
   logic e_ready = 0, e_ws = 0, e_ur = 0, m_push = 0;
   logic [7:0] e_byte = '0;
   logic [47:0] words[2] = '{48'h0123456789AB, 48'hFEDCBA987654};

   always #5 clk = ~clk;

   ui_lvds_tx dut (
      .w_lvds_clk(clk), .I_rstn(rstn), .I_enable(enable), .I_train(train),
      .I_data(data), .I_valid(valid), .O_ready(ready), .O_d1(d1), .O_d2(d2),
      .O_word_start(word_start), .O_underrun(underrun)
   );

   task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[47:0];
   endfunction

   // Link mode the model moves to if the current edge ends a word: 0 idle, 1 train, 2 data.
   function automatic int next_mode();
      if (!enable) return 0;
      if (mode == 1) return (!train && hold.size() > 0) ? 2 : 1;
      return train ? 1 : 2;
   endfunction

   task automatic load(logic [47:0] w);
      for (int k = 0; k < 6; k++) q.push_back(w[47-8*k -: 8]);
   endtask

   task automatic model_reset();
      mode = 0;
      q.delete();
      hold.delete();
      rx_n = 0;
   endtask

   task automatic tick();
      int nm;
      @(negedge clk);
      nm = next_mode();
      e_ready = mode != 0 && (hold.size() == 0 || (q.size() == 1 && nm == 2));
      check("ready", 48'(ready), 48'(e_ready));
      m_push = valid && e_ready;
      @(posedge clk);
      e_ur = 0;
      e_ws = 0;
      e_byte = 0;
      if (mode == 0) begin
         if (enable) begin
            mode = 1;
            load(TRAIN_WORD);
         end
      end else begin
         e_ws = q.size() == 6;
         e_byte = q.pop_front();
         if (q.size() == 0) begin
            if (nm == 0) begin
               mode = 0;
               hold.delete();
            end else begin
               if (nm == 2 && hold.size() > 0) load(hold.pop_front());
               else begin
                  load(TRAIN_WORD);
                  e_ur = mode == 2 && nm == 2;
               end
               mode = nm;
            end
         end
         if (m_push && mode != 0) hold.push_back(data);
      end
      #1;
      check("d1", 48'(d1), 48'(e_byte[7:4]));
      check("d2", 48'(d2), 48'(e_byte[3:0]));
      check("word_start", 48'(word_start), 48'(e_ws));
      check("underrun", 48'(underrun), 48'(e_ur));
      if (word_start) begin
         rx_n = 1;
         rx_acc = {40'd0, d1, d2};
      end else if (rx_n > 0 && rx_n < 6) begin
         rx_acc = {rx_acc[39:0], d1, d2};
         rx_n++;
         if (rx_n == 6) rx_words.push_back(rx_acc);
      end
   endtask

   task automatic check_zero(string tag);
      check({tag, "_out"}, 48'({d1, d2, word_start, underrun}), 48'd0);
      check({tag, "_ready"}, 48'(ready), 48'd0);
   endtask

   initial begin
      int idx, n_ur;
      logic found;
      #2 rstn = 0;
      #1 check_zero("reset");
      @(posedge clk);
      #1 check_zero("reset_edge");
      rstn = 1;
      model_reset();
      repeat (20) tick();
      check_zero("idle");
      enable = 1;
      train = 1;
      tick();
      tick();
      check("train_first_d1", 48'(d1), 48'hF);
      check("train_first_d2", 48'(d2), 48'hF);
      check("train_first_ws", 48'(word_start), 48'd1);
      repeat (22) tick();
      rx_words.delete();
      train = 0;
      valid = 1;
      idx = 0;
      data = words[0];
      for (int i = 0; i < 40 && idx < 2; i++) begin
         tick();
         if (m_push) begin
            idx++;
            data = idx < 2 ? words[1] : rnd();
         end
      end
      valid = 0;
      check("stream_accepts", 48'(idx), 48'd2);
      repeat (14) tick();
      found = 0;
      for (int i = 0; i + 1 < rx_words.size(); i++)
         if (rx_words[i] == words[0] && rx_words[i+1] == words[1]) found = 1;
      check("stream_loopback", 48'(found), 48'd1);
      n_ur = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_ur += int'(underrun);
      end
      check("underrun_count", 48'(n_ur), 48'd2);
      valid = 1;
      data = rnd();
      for (int i = 0; i < 30 && !(mode == 2 && q.size() == 4); i++) begin
         tick();
         if (m_push) data = rnd();
      end
      check("reach_cnt2", 48'(mode == 2 && q.size() == 4), 48'd1);
      train = 1;
      repeat (14) begin
         tick();
         if (m_push) data = rnd();
      end
      train = 0;
      for (int i = 0; i < 30 && !(mode == 2 && q.size() == 3); i++) begin
         tick();
         if (m_push) data = rnd();
      end
      check("reach_cnt3", 48'(mode == 2 && q.size() == 3), 48'd1);
      enable = 0;
      repeat (10) tick();
      check_zero("enable_drop");
      enable = 1;
      for (int i = 0; i < 40 && !(mode == 2 && q.size() == 5); i++) begin
         tick();
         if (m_push) data = rnd();
      end
      check("reach_cnt1", 48'(mode == 2 && q.size() == 5), 48'd1);
      #2 rstn = 0;
      #1 check_zero("async_reset");
      model_reset();
      @(posedge clk);
      #1 check_zero("async_reset_edge");
      rstn = 1;
      for (int i = 0; i < 1500; i++) begin
         valid = ($urandom() % 4) != 0;
         data = rnd();
         if ($urandom() % 40 == 0) train = !train;
         if ($urandom() % 120 == 0) enable = !enable;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
